// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and widths for the clock-divider ratio controller.
// Imported by clk_div_ratio_ctrl and clk_div_lock_timer.
package clk_div_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        LOAD   = 2'd2,
        RELOCK = 2'd3
    } state_t;

    localparam int RATIO_W_DEF = 8;
    localparam int SETTLE_W    = 4;
    localparam int PERIOD_W    = 3;

endpackage

// File: rtl/clk_div_lock_timer.sv
// Nested cycle/period counter: done marks the last ref cycle of the
// final divided-clock period after start.
module clk_div_lock_timer
    import clk_div_ctrl_pkg::*;
#(
    parameter int RATIO_W = RATIO_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [RATIO_W-1:0]  ratio,
    input  logic [PERIOD_W-1:0] periods,
    output logic                done
);

    logic [RATIO_W-1:0]  cyc;
    logic [RATIO_W-1:0]  eff;
    logic [PERIOD_W-1:0] per;
    logic                wrap;

    // Ratio 0 never reaches the divider; 1 means bypass (one cycle per period)
    assign eff  = (ratio <= RATIO_W'(1)) ? RATIO_W'(1) : ratio;
    assign wrap = (cyc == eff - RATIO_W'(1));
    assign done = wrap && (per == periods - PERIOD_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc <= '0;
            per <= '0;
        end else if (start) begin
            cyc <= '0;
            per <= '0;
        end else if (wrap) begin
            cyc <= '0;
            per <= per + PERIOD_W'(1);
        end else begin
            cyc <= cyc + RATIO_W'(1);
        end
    end

endmodule

// File: rtl/clk_div_ratio_ctrl.sv
// Ratio-change sequencer for the integer clock divider.
// Optional reconfiguration counter: define CLK_DIV_RECONF_CNT_EN.
module clk_div_ratio_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int RATIO_W       = RATIO_W_DEF,
    parameter int SETTLE_CYC    = 4,
    parameter int LOCK_PERIODS  = 2,
    parameter int DEFAULT_RATIO = 1
) (
    input  logic               i_ref_clk,
    input  logic               i_rst_n,
    input  logic               i_clk_en,
    input  logic               i_req_valid,
    input  logic [RATIO_W-1:0] i_req_ratio,
    output logic               o_req_ready,
    output logic [RATIO_W-1:0] o_div_ratio,
    output logic               o_div_en,
    output logic               o_busy,
    output logic               o_locked,
    output logic               o_cfg_err,
    output logic [7:0]         o_reconf_cnt
);

    state_t              state;
    logic [RATIO_W-1:0]  pending;
    logic [SETTLE_W-1:0] settle;
    logic                start;
    logic                done;

    assign o_req_ready = (state == IDLE);

    // Timer restarts on every transition into RELOCK
    assign start = ((state == IDLE) && !i_req_valid && i_clk_en && !o_locked)
                 || ((state == LOAD) && i_clk_en);

    clk_div_lock_timer #(
        .RATIO_W (RATIO_W)
    ) u_timer (
        .clk     (i_ref_clk),
        .rst_n   (i_rst_n),
        .start   (start),
        .ratio   (o_div_ratio),
        .periods (PERIOD_W'(LOCK_PERIODS)),
        .done    (done)
    );

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            pending     <= '0;
            settle      <= '0;
            o_div_ratio <= RATIO_W'(DEFAULT_RATIO);
            o_div_en    <= 1'b0;
            o_busy      <= 1'b0;
            o_locked    <= 1'b0;
            o_cfg_err   <= 1'b0;
        end else begin
            o_cfg_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    o_div_en <= i_clk_en;
                    if (!i_clk_en) o_locked <= 1'b0;
                    if (i_req_valid) begin
                        if (i_req_ratio == '0) begin
                            o_cfg_err <= 1'b1;
                        end else if (i_req_ratio != o_div_ratio) begin
                            pending  <= i_req_ratio;
                            settle   <= '0;
                            o_busy   <= 1'b1;
                            o_locked <= 1'b0;
                            o_div_en <= 1'b0;
                            state    <= DRAIN;
                        end
                    end else if (i_clk_en && !o_locked) begin
                        o_busy <= 1'b1;
                        state  <= RELOCK;
                    end
                end
                DRAIN: begin
                    if (settle == SETTLE_W'(SETTLE_CYC - 1)) begin
                        o_div_ratio <= pending;
                        state       <= LOAD;
                    end else begin
                        settle <= settle + SETTLE_W'(1);
                    end
                end
                LOAD: begin
                    if (i_clk_en) begin
                        o_div_en <= 1'b1;
                        state    <= RELOCK;
                    end else begin
                        o_busy   <= 1'b0;
                        o_locked <= 1'b0;
                        state    <= IDLE;
                    end
                end
                RELOCK: begin
                    if (!i_clk_en) begin
                        o_div_en <= 1'b0;
                        o_busy   <= 1'b0;
                        state    <= IDLE;
                    end else if (done) begin
                        o_locked <= 1'b1;
                        o_busy   <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CLK_DIV_RECONF_CNT_EN
    logic [7:0] reconf_cnt;

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            reconf_cnt <= '0;
        end else if ((state == LOAD) && (reconf_cnt != 8'hFF)) begin
            reconf_cnt <= reconf_cnt + 8'd1;
        end
    end

    assign o_reconf_cnt = reconf_cnt;
`else
    assign o_reconf_cnt = '0;
`endif

endmodule

// File: tb/tb_clk_div_ratio_ctrl.sv
// Directed bench for clk_div_ratio_ctrl: reset, relock, ratio change,
// reject, no-op request, enable abort, reset mid-sequence.
module tb_clk_div_ratio_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clk_en;
    logic       req_valid;
    logic [7:0] req_ratio;
    logic       req_ready;
    logic [7:0] div_ratio;
    logic       div_en;
    logic       busy;
    logic       locked;
    logic       cfg_err;
    logic [7:0] reconf_cnt;

    int checks   = 0;
    int failures = 0;
    int n;

`ifdef CLK_DIV_RECONF_CNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    clk_div_ratio_ctrl dut (
        .i_ref_clk    (clk),
        .i_rst_n      (rst_n),
        .i_clk_en     (clk_en),
        .i_req_valid  (req_valid),
        .i_req_ratio  (req_ratio),
        .o_req_ready  (req_ready),
        .o_div_ratio  (div_ratio),
        .o_div_en     (div_en),
        .o_busy       (busy),
        .o_locked     (locked),
        .o_cfg_err    (cfg_err),
        .o_reconf_cnt (reconf_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts cycles until o_locked rises, bounded
    task automatic wait_lock(output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!locked && cyc < 64);
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!req_ready && cyc < 64);
    endtask

    initial begin
        rst_n     = 1'b0;
        clk_en    = 1'b1;
        req_valid = 1'b0;
        req_ratio = 8'd0;
        repeat (3) step();

        check("rst_ratio", div_ratio, 1);
        check("rst_div_en", div_en, 0);
        check("rst_busy", busy, 0);
        check("rst_locked", locked, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_ready", req_ready, 1);
        check("rst_reconf", reconf_cnt, 0);

        // Reset release with enable high: relock at ratio 1
        rst_n = 1'b1;
        step();
        check("boot_busy", busy, 1);
        check("boot_div_en", div_en, 1);
        check("boot_ready", req_ready, 0);
        check("boot_locked0", locked, 0);
        step();
        check("boot_locked1", locked, 0);
        step();
        check("boot_locked2", locked, 1);
        check("boot_busy_done", busy, 0);
        check("boot_ratio", div_ratio, 1);

        // Change to ratio 6
        req_valid = 1'b1;
        req_ratio = 8'd6;
        step();
        req_valid = 1'b0;
        check("r6_drain_en", div_en, 0);
        check("r6_drain_ready", req_ready, 0);
        check("r6_drain_busy", busy, 1);
        check("r6_drain_locked", locked, 0);
        repeat (3) step();
        check("r6_drain_ratio", div_ratio, 1);
        check("r6_drain_en_late", div_en, 0);
        step();
        check("r6_load_ratio", div_ratio, 6);
        check("r6_load_en", div_en, 0);
        check("r6_load_busy", busy, 1);
        step();
        check("r6_relock_en", div_en, 1);
        check("r6_relock_busy", busy, 1);
        wait_lock(n);
        check("r6_lock_cycles", n, 12);
        check("r6_busy_done", busy, 0);
        check("r6_reconf", reconf_cnt, CNT_ON * 1);

        // Reject ratio 0
        req_valid = 1'b1;
        req_ratio = 8'd0;
        step();
        req_valid = 1'b0;
        check("r0_err", cfg_err, 1);
        check("r0_ratio", div_ratio, 6);
        check("r0_locked", locked, 1);
        check("r0_ready", req_ready, 1);
        step();
        check("r0_err_pulse", cfg_err, 0);

        // Same ratio: consumed, no sequence
        req_valid = 1'b1;
        req_ratio = 8'd6;
        step();
        req_valid = 1'b0;
        check("same_ready", req_ready, 1);
        check("same_en", div_en, 1);
        check("same_locked", locked, 1);
        check("same_busy", busy, 0);
        step();
        check("same_en2", div_en, 1);
        check("same_err", cfg_err, 0);

        // Ratio 5, abort after one period
        req_valid = 1'b1;
        req_ratio = 8'd5;
        step();
        req_valid = 1'b0;
        repeat (4) step();
        check("r5_load_ratio", div_ratio, 5);
        step();
        check("r5_relock_en", div_en, 1);
        repeat (5) step();
        check("r5_mid_locked", locked, 0);
        clk_en = 1'b0;
        step();
        check("abort_ready", req_ready, 1);
        check("abort_en", div_en, 0);
        check("abort_locked", locked, 0);
        check("abort_busy", busy, 0);
        step();
        check("abort_idle_en", div_en, 0);
        check("abort_reconf", reconf_cnt, CNT_ON * 2);
        clk_en = 1'b1;
        step();
        check("rerelock_en", div_en, 1);
        check("rerelock_busy", busy, 1);
        wait_lock(n);
        check("r5_lock_cycles", n, 10);

        // Reset in DRAIN discards the request
        req_valid = 1'b1;
        req_ratio = 8'd9;
        step();
        req_valid = 1'b0;
        check("r9_drain_busy", busy, 1);
        step();
        clk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("r9_rst_ratio", div_ratio, 1);
        check("r9_rst_en", div_en, 0);
        check("r9_rst_busy", busy, 0);
        check("r9_rst_locked", locked, 0);
        check("r9_rst_ready", req_ready, 1);
        check("r9_rst_reconf", reconf_cnt, 0);
        step();
        rst_n = 1'b1;
        step();
        check("r9_after_ratio", div_ratio, 1);

        // Three changes with enable low: LOAD returns to IDLE
        for (int i = 2; i <= 4; i++) begin
            req_valid = 1'b1;
            req_ratio = 8'(i);
            step();
            req_valid = 1'b0;
            wait_ready(n);
            check("noen_cycles", n, 5);
        end
        check("noen_ratio", div_ratio, 4);
        check("noen_locked", locked, 0);
        check("noen_en", div_en, 0);
        check("noen_busy", busy, 0);
        check("noen_reconf", reconf_cnt, CNT_ON * 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_div_ratio_ctrl.md
Name: clk_div_ratio_ctrl

Overview:
Configuration sequencer for the integer clock divider. Accepts ratio-change requests from the system/register-file side over a valid/ready handshake. Drives the divider's ratio and enable so that a ratio change happens only while the divider is disabled. After each change, the divider runs for a fixed number of output periods before o_locked asserts, so downstream consumers (e.g. UART TX/RX clocking) only use the divided clock once it is stable.

Parameters:
RATIO_W, 8, width of the division ratio.
SETTLE_CYC, 4, ref-clock cycles the divider is held disabled before a new ratio is loaded (range 1..15).
LOCK_PERIODS, 2, full divided-clock periods counted before o_locked asserts (range 1..7).
DEFAULT_RATIO, 1, value of o_div_ratio out of reset.

Ports:
i_ref_clk  in  1  reference clock, same clock as the divider.
i_rst_n  in  1  asynchronous active-low reset.
i_clk_en  in  1  software enable for the divided clock.
i_req_valid  in  1  ratio-change request valid.
i_req_ratio  in  RATIO_W  requested ratio.
o_req_ready  out  1  controller can accept a request.
o_div_ratio  out  RATIO_W  ratio to the divider.
o_div_en  out  1  enable to the divider.
o_busy  out  1  reconfiguration in progress.
o_locked  out  1  divided clock is stable at o_div_ratio.
o_cfg_err  out  1  one-cycle pulse when a request is rejected.
o_reconf_cnt  out  8  completed-reconfiguration count (optional feature).

Behaviour:
- Clock and reset: one clock, i_ref_clk; reset is asynchronous and active-low on i_rst_n.
- All outputs are registered, except o_req_ready, which is decoded from the state.
- Reset values: state IDLE, o_div_ratio=DEFAULT_RATIO, o_div_en=0, o_busy=0, o_locked=0, o_cfg_err=0, o_reconf_cnt=0. Reset mid-sequence abandons the sequence and applies these values.
- Internal counters: SETTLE counter (4 bit); cycle counter (RATIO_W bit, counts 0..eff_ratio-1); period counter (3 bit).
- Effective ratio: eff_ratio = o_div_ratio, with a value of 1 treated as 1 ref cycle per period (bypass).
- FSM states: IDLE, DRAIN, LOAD, RELOCK.
- IDLE:
  - o_req_ready=1; o_busy=0; o_div_en=i_clk_en (registered).
  - Request accepted on i_req_valid & o_req_ready.
  - Accept with i_req_ratio==0: o_cfg_err pulses for 1 cycle; no other change; stay IDLE.
  - Accept with i_req_ratio==o_div_ratio: request consumed; no sequence; o_locked unchanged.
  - Any other accepted ratio: latch it into the pending register; o_busy=1, o_locked=0, o_div_en=0; go to DRAIN.
  - No request, i_clk_en=1, o_locked=0: go to RELOCK.
  - i_clk_en=0: o_locked=0 and o_div_en=0 on the next cycle.
  - A request takes priority over the enable-driven relock in the same cycle.
- DRAIN:
  - o_div_en=0; o_req_ready=0.
  - Hold SETTLE_CYC cycles, then go to LOAD.
- LOAD:
  - 1 cycle; o_div_ratio <= pending value; o_div_en stays 0.
  - Next state is RELOCK if i_clk_en=1, else IDLE with o_locked=0.
  - If the next state is IDLE, o_reconf_cnt still increments.
- RELOCK:
  - o_div_en=1; o_busy=1; counters clear on entry.
  - When the cycle counter reaches eff_ratio-1, it wraps and the period counter increments.
  - When the period counter reaches LOCK_PERIODS, o_locked=1 and the state goes to IDLE.
  - Total latency: eff_ratio*LOCK_PERIODS cycles after RELOCK entry.
  - If i_clk_en falls: abort to IDLE; o_div_en=0; o_locked stays 0.
  - Requests are not accepted in RELOCK.
- Requests are accepted only in IDLE. A request held valid through a busy period is accepted on the first cycle IDLE is re-entered.
- Typical request-to-lock latency: 1 (accept) + SETTLE_CYC + 1 (LOAD) + eff_ratio*LOCK_PERIODS cycles.

Optional Feature:
CLK_DIV_RECONF_CNT_EN:
- Defined: o_reconf_cnt is an 8-bit saturating counter (stops at 255), incremented on every LOAD cycle.
- Undefined: o_reconf_cnt is tied to 0 and no counter flops are inferred. The port list is identical in both builds.

Decomposition:
- Package clk_div_ctrl_pkg holds:
  - the FSM state typedef (IDLE, DRAIN, LOAD, RELOCK, 2-bit encoding);
  - the default RATIO_W;
  - the SETTLE/period counter widths.
- One natural sub-module, clk_div_lock_timer: the nested cycle/period counter. It has inputs start, ratio, periods and output done; RELOCK instantiates it.

Test Plan:
- Reset release with i_clk_en=1 and DEFAULT_RATIO=1 -> RELOCK; o_locked=1 exactly 2 cycles after entry; o_div_ratio=1.
- IDLE, i_clk_en=1, request ratio 6 -> o_div_en low for 4+1 cycles; o_div_ratio=6 on the LOAD cycle; o_locked rises 12 cycles after RELOCK entry; o_busy high throughout.
- Request ratio 0 -> o_cfg_err pulses 1 cycle; o_div_ratio and o_locked unchanged; o_req_ready stays 1.
- Request equal to current ratio 6 -> consumed in 1 cycle; o_div_en never drops; o_locked stays 1.
- i_clk_en dropped mid-RELOCK (ratio 5, period 1) -> next cycle IDLE; o_div_en=0; o_locked=0. Re-raise i_clk_en -> fresh 10-cycle relock.
- Assert i_rst_n=0 in DRAIN after a request for ratio 9 -> immediate reset values; o_div_ratio=1; request discarded. With CLK_DIV_RECONF_CNT_EN defined, 3 completed changes -> o_reconf_cnt=3.
